// File: rtl/riscv_pkg.sv
// Shared RV32I types plus the retire record and error codes used by the retire checker.
// Latency: none, types and pure functions only.
// Backpressure: not applicable.
package riscv_pkg;

  localparam int XLEN = 32;

  // One retired instruction as seen at write-back.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;
  } retire_rec_t;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_MISMATCH  = 3'd1,
    ERR_UNDERFLOW = 3'd2,
    ERR_OVERFLOW  = 3'd3,
    ERR_TIMEOUT   = 3'd4
  } checker_err_e;

  // Bit positions inside the 4-bit field-mismatch vector {pc, instr, rd_addr, rd_data}.
  localparam int FLD_RD_DATA = 0;
  localparam int FLD_RD_ADDR = 1;
  localparam int FLD_INSTR   = 2;
  localparam int FLD_PC      = 3;

  // Per-field mismatch bits. Write-back data only matters when the expected record writes a register.
  function automatic logic [3:0] rec_diff(retire_rec_t exp_rec, retire_rec_t act_rec);
    logic [3:0] d;
    d = '0;
    d[FLD_PC]      = (exp_rec.pc      != act_rec.pc);
    d[FLD_INSTR]   = (exp_rec.instr   != act_rec.instr);
    d[FLD_RD_ADDR] = (exp_rec.rd_addr != act_rec.rd_addr);
    d[FLD_RD_DATA] = (exp_rec.rd_addr != 5'd0) && (exp_rec.rd_data != act_rec.rd_data);
    return d;
  endfunction

endpackage

// File: rtl/retire_checker_if.sv
// Bundle of the model retire stream, the core retire stream and the checker status outputs.
// Latency: none, wiring only.
// Backpressure: model_ready_o gates the model side; the core side is never stalled.
interface retire_checker_if #(
  parameter int DEPTH = 8
);
  import riscv_pkg::*;

  logic                     model_valid_i;
  logic [XLEN-1:0]          model_pc_i;
  logic [XLEN-1:0]          model_instr_i;
  logic [4:0]               model_rd_addr_i;
  logic [XLEN-1:0]          model_rd_data_i;
  logic                     model_ready_o;

  logic                     dut_valid_i;
  logic [XLEN-1:0]          dut_pc_i;
  logic [XLEN-1:0]          dut_instr_i;
  logic [4:0]               dut_rd_addr_i;
  logic [XLEN-1:0]          dut_rd_data_i;

  logic                     fail_o;
  checker_err_e             err_o;
  logic [3:0]               err_fields_o;
  logic [XLEN-1:0]          err_pc_o;
  logic [31:0]              retired_cnt_o;
  logic [$clog2(DEPTH):0]   level_o;

  // Environment side: drives both retire streams, observes status.
  modport master (
    output model_valid_i, model_pc_i, model_instr_i, model_rd_addr_i, model_rd_data_i,
    output dut_valid_i, dut_pc_i, dut_instr_i, dut_rd_addr_i, dut_rd_data_i,
    input  model_ready_o, fail_o, err_o, err_fields_o, err_pc_o, retired_cnt_o, level_o
  );

  // Checker side.
  modport slave (
    input  model_valid_i, model_pc_i, model_instr_i, model_rd_addr_i, model_rd_data_i,
    input  dut_valid_i, dut_pc_i, dut_instr_i, dut_rd_addr_i, dut_rd_data_i,
    output model_ready_o, fail_o, err_o, err_fields_o, err_pc_o, retired_cnt_o, level_o
  );

endinterface

// File: rtl/retire_fifo.sv
// Synchronous FIFO of retire records with extra-MSB pointers for full/empty.
// Latency: push visible at the head and in level one cycle later; head read is combinational.
// Backpressure: caller must not push when full unless popping in the same cycle.
module retire_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push,
  input  retire_rec_t            wr_rec,
  input  logic                   pop,
  output retire_rec_t            rd_rec,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  retire_rec_t   mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // Pointer advance; the extra MSB tells a full ring from an empty one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; a push while full and popping lands in the slot being vacated.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_rec;
  end

  assign rd_rec = mem[rd_ptr[AW-1:0]];
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level  = wr_ptr - rd_ptr;

endmodule

// File: rtl/retire_checker.sv
// Lock-step retire checker: queues reference-model retires, compares each core retire against the head.
// Latency: errors and retired count register on the edge after the offending/matching core retire.
// Backpressure: model_ready_o drops when the queue is full or after a failure; core side never stalls.
module retire_checker
  import riscv_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  retire_checker_if.slave    bus
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic {ST_RUN, ST_FAIL} state_e;

  state_e        state_q, state_d;
  checker_err_e  err_d, err_q;
  logic [3:0]    fields_q;
  logic [XLEN-1:0] err_pc_q;
  logic [31:0]   cnt_q;
  logic [IW-1:0] idle_q;

  retire_rec_t   model_rec, dut_rec, head_rec;
  logic          full, empty, push, pop, run;
  logic [LW-1:0] level;
  logic [3:0]    diff;

  assign model_rec = '{pc: bus.model_pc_i, instr: bus.model_instr_i,
                       rd_addr: bus.model_rd_addr_i, rd_data: bus.model_rd_data_i};
  assign dut_rec   = '{pc: bus.dut_pc_i, instr: bus.dut_instr_i,
                       rd_addr: bus.dut_rd_addr_i, rd_data: bus.dut_rd_data_i};

  assign run  = (state_q == ST_RUN);
  assign pop  = run && bus.dut_valid_i && !empty;
  // Full queue still accepts a record when the head leaves in the same cycle.
  assign push = run && bus.model_valid_i && (!full || pop);
  assign diff = rec_diff(head_rec, dut_rec);

  retire_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push   (push),
    .wr_rec (model_rec),
    .pop    (pop),
    .rd_rec (head_rec),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Error detection in priority order; any error moves to FAIL for good.
  always_comb begin
    state_d = state_q;
    err_d   = ERR_NONE;
    if (state_q == ST_RUN) begin
      if (pop && (diff != 4'd0))
        err_d = ERR_MISMATCH;
      else if (bus.dut_valid_i && empty)
        err_d = ERR_UNDERFLOW;
      else if (bus.model_valid_i && full && !pop)
        err_d = ERR_OVERFLOW;
      else if (!empty && !pop && (idle_q == IW'(TIMEOUT - 1)))
        err_d = ERR_TIMEOUT;
      if (err_d != ERR_NONE) state_d = ST_FAIL;
    end
  end

  // Capture the first failure; the head pc is the instruction the core was expected to retire.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q    <= ERR_NONE;
      fields_q <= '0;
      err_pc_q <= '0;
    end else if (run && (state_d == ST_FAIL)) begin
      err_q    <= err_d;
      fields_q <= (err_d == ERR_MISMATCH) ? diff : 4'd0;
      err_pc_q <= empty ? '0 : head_rec.pc;
    end
  end

  // Retired count and idle watchdog; both freeze once failed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      idle_q <= '0;
    end else if (run) begin
      if (pop && (diff == 4'd0)) cnt_q <= cnt_q + 32'd1;
      idle_q <= (pop || empty) ? '0 : idle_q + 1'b1;
    end
  end

  assign bus.model_ready_o = run && !full;
  assign bus.fail_o        = (state_q == ST_FAIL);
  assign bus.err_o         = err_q;
  assign bus.err_fields_o  = fields_q;
  assign bus.err_pc_o      = err_pc_q;
  assign bus.retired_cnt_o = cnt_q;
  assign bus.level_o       = level;

endmodule

// File: tb/tb_retire_checker.sv
module tb_retire_checker;
  import riscv_pkg::*;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  retire_checker_if #(.DEPTH(DEPTH)) bus ();
  retire_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic         fail;
    checker_err_e err;
    logic [3:0]   fields;
    logic [31:0]  pc;
    logic [31:0]  cnt;
    int           level;
    logic         ready;
  } snap_t;

  snap_t        exp_q[$];
  retire_rec_t  ref_q[$];
  bit           r_fail;
  checker_err_e r_err;
  logic [3:0]   r_fields;
  logic [31:0]  r_pc;
  logic [31:0]  r_cnt;
  int           r_idle;

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
    end
  endtask

  // Reference model: a plain queue plus a cycle count since the last pop.
  function automatic void model_step(bit rs, bit mv, retire_rec_t mrec, bit dv, retire_rec_t drec);
    int sz;
    bit empty, full, pop;
    logic [3:0] f;
    checker_err_e e;
    retire_rec_t h;
    if (rs) begin
      ref_q.delete();
      r_fail = 0; r_err = ERR_NONE; r_fields = 0; r_pc = 0; r_cnt = 0; r_idle = 0;
      return;
    end
    if (r_fail) return;
    sz = ref_q.size();
    empty = (sz == 0);
    full  = (sz == DEPTH);
    pop   = dv && !empty;
    f = 4'd0;
    e = ERR_NONE;
    if (pop) begin
      h = ref_q[0];
      f = {h.pc != drec.pc, h.instr != drec.instr, h.rd_addr != drec.rd_addr,
           (h.rd_addr != 5'd0) && (h.rd_data != drec.rd_data)};
    end
    if (f != 4'd0)                          e = ERR_MISMATCH;
    else if (dv && empty)                   e = ERR_UNDERFLOW;
    else if (mv && full && !pop)            e = ERR_OVERFLOW;
    else if (!empty && !pop && r_idle + 1 >= TIMEOUT) e = ERR_TIMEOUT;
    if (e != ERR_NONE) begin
      r_fail = 1; r_err = e; r_fields = f;
      r_pc = empty ? 32'd0 : ref_q[0].pc;
      return;
    end
    if (pop) begin
      void'(ref_q.pop_front());
      r_cnt++;
    end
    if (mv) ref_q.push_back(mrec);
    r_idle = (pop || empty) ? 0 : r_idle + 1;
  endfunction

  function automatic snap_t ref_snap();
    snap_t s;
    s.fail = r_fail; s.err = r_err; s.fields = r_fields; s.pc = r_pc; s.cnt = r_cnt;
    s.level = ref_q.size();
    s.ready = !r_fail && (ref_q.size() < DEPTH);
    return s;
  endfunction

  task automatic cycle(bit rs, bit mv, retire_rec_t mrec, bit dv, retire_rec_t drec);
    rst                 = rs;
    bus.model_valid_i   = mv;
    bus.model_pc_i      = mrec.pc;
    bus.model_instr_i   = mrec.instr;
    bus.model_rd_addr_i = mrec.rd_addr;
    bus.model_rd_data_i = mrec.rd_data;
    bus.dut_valid_i     = dv;
    bus.dut_pc_i        = drec.pc;
    bus.dut_instr_i     = drec.instr;
    bus.dut_rd_addr_i   = drec.rd_addr;
    bus.dut_rd_data_i   = drec.rd_data;
    model_step(rs, mv, mrec, dv, drec);
    @(posedge clk);
    exp_q.push_back(ref_snap());
    #1;
  endtask

  // Monitor: every post-edge snapshot is compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      snap_t e;
      e = exp_q.pop_front();
      chk("sb_fail",   32'(bus.fail_o),        32'(e.fail));
      chk("sb_err",    32'(bus.err_o),         32'(e.err));
      chk("sb_fields", 32'(bus.err_fields_o),  32'(e.fields));
      chk("sb_pc",     bus.err_pc_o,           e.pc);
      chk("sb_cnt",    bus.retired_cnt_o,      e.cnt);
      chk("sb_ready",  32'(bus.model_ready_o), 32'(e.ready));
      if (!e.fail) chk("sb_level", 32'(bus.level_o), 32'(e.level));
    end
  end

  // addi x(i+1), x0, 8*i at pc 0x8000_0000 + 4*i
  function automatic retire_rec_t addi_rec(int i);
    retire_rec_t r;
    r.pc      = 32'h8000_0000 + 32'(4 * i);
    r.instr   = (32'(8 * i) << 20) | (32'(i + 1) << 7) | 32'h13;
    r.rd_addr = 5'(i + 1);
    r.rd_data = 32'(8 * i);
    return r;
  endfunction

  task automatic do_reset();
    retire_rec_t z;
    z = '0;
    cycle(1, 0, z, 0, z);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_fail"},   32'(bus.fail_o),        0);
    chk({tag, "_err"},    32'(bus.err_o),         0);
    chk({tag, "_fields"}, 32'(bus.err_fields_o),  0);
    chk({tag, "_pc"},     bus.err_pc_o,           0);
    chk({tag, "_cnt"},    bus.retired_cnt_o,      0);
    chk({tag, "_level"},  32'(bus.level_o),       0);
    chk({tag, "_ready"},  32'(bus.model_ready_o), 1);
  endtask

  initial begin
    retire_rec_t z, r, st, d;
    int w;
    z = '0;
    do_reset();
    do_reset();
    chk_reset_outputs("rst0");

    // In-order replay three cycles behind the model.
    for (int c = 0; c < 10; c++)
      cycle(0, c < 5, addi_rec(c), (c >= 3) && (c < 8), addi_rec(c - 3));
    chk("replay_cnt",   bus.retired_cnt_o, 5);
    chk("replay_fail",  32'(bus.fail_o), 0);
    chk("replay_level", 32'(bus.level_o), 0);

    // Write-back data mismatch on the third record.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      d = addi_rec(c - 3);
      if (c == 5) d.rd_data = 32'h11;
      cycle(0, c < 5, addi_rec(c), (c >= 3) && (c < 8), d);
      if (c == 5) chk("mm_fail_next_edge", 32'(bus.fail_o), 1);
    end
    chk("mm_err",    32'(bus.err_o), 32'(ERR_MISMATCH));
    chk("mm_fields", 32'(bus.err_fields_o), 32'b0001);
    chk("mm_pc",     bus.err_pc_o, 32'h8000_0008);
    chk("mm_cnt",    bus.retired_cnt_o, 2);

    // Store: rd_data ignored, rd_addr still compared.
    do_reset();
    st.pc = 32'h8000_0100; st.instr = 32'h0011_2023; st.rd_addr = 5'd0; st.rd_data = 32'h1234;
    cycle(0, 1, st, 0, z);
    d = st; d.rd_data = 32'hdead_beef;
    cycle(0, 0, z, 1, d);
    chk("st_nofail", 32'(bus.fail_o), 0);
    chk("st_cnt",    bus.retired_cnt_o, 1);
    cycle(0, 1, st, 0, z);
    d.rd_addr = 5'd1;
    cycle(0, 0, z, 1, d);
    chk("st_fields", 32'(bus.err_fields_o), 32'b0010);
    chk("st_err",    32'(bus.err_o), 32'(ERR_MISMATCH));

    // Underflow, with and without a same-cycle push.
    do_reset();
    cycle(0, 0, z, 1, addi_rec(0));
    chk("uf_err", 32'(bus.err_o), 32'(ERR_UNDERFLOW));
    do_reset();
    cycle(0, 1, addi_rec(0), 1, addi_rec(0));
    chk("uf_push_err", 32'(bus.err_o), 32'(ERR_UNDERFLOW));

    // Full queue: push+pop legal, lone push overflows.
    do_reset();
    for (int c = 0; c < DEPTH; c++) cycle(0, 1, addi_rec(c), 0, z);
    chk("full_level", 32'(bus.level_o), DEPTH);
    chk("full_ready", 32'(bus.model_ready_o), 0);
    cycle(0, 1, addi_rec(8), 1, addi_rec(0));
    chk("pp_fail",  32'(bus.fail_o), 0);
    chk("pp_level", 32'(bus.level_o), DEPTH);
    cycle(0, 1, addi_rec(9), 0, z);
    chk("of_err",   32'(bus.err_o), 32'(ERR_OVERFLOW));
    chk("of_ready", 32'(bus.model_ready_o), 0);

    // Stall watchdog.
    do_reset();
    cycle(0, 1, addi_rec(0), 0, z);
    for (int c = 1; c < TIMEOUT; c++) cycle(0, 0, z, 0, z);
    chk("to_not_yet", 32'(bus.fail_o), 0);
    cycle(0, 0, z, 0, z);
    chk("to_err", 32'(bus.err_o), 32'(ERR_TIMEOUT));
    chk("to_pc",  bus.err_pc_o, 32'h8000_0000);
    do_reset();
    chk_reset_outputs("rst1");

    // Randomized traffic against the queue model.
    for (int n = 0; n < 3000; n++) begin
      bit rs, mv, dv;
      rs = r_fail ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
      mv = (ref_q.size() < DEPTH) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      dv = ((n % 500) < 80) ? 1'b0 : ($urandom_range(0, 9) < 4);
      r.pc = $urandom; r.instr = $urandom;
      r.rd_addr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      r.rd_data = $urandom;
      if (ref_q.size() > 0) d = ref_q[0];
      else begin
        d.pc = $urandom; d.instr = $urandom; d.rd_addr = 5'($urandom); d.rd_data = $urandom;
      end
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 3))
          0: d.pc      = d.pc ^ 32'h4;
          1: d.instr   = d.instr ^ 32'h100;
          2: d.rd_addr = d.rd_addr ^ 5'h1;
          default: d.rd_data = d.rd_data ^ 32'h1;
        endcase
      end
      cycle(rs, mv, r, dv, d);
    end

    w = 0;
    while (exp_q.size() > 0 && w < 5) begin
      @(negedge clk);
      w++;
    end
    #1;
    chk("drain_pending", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/retire_checker.md
# retire_checker

Lock-step retire-stream checker downstream of the single-cycle RV32I reference model. It buffers the model's per-instruction retire records (pc, instr, rd address, rd data) in a FIFO. Each retire record from the pipelined core is compared against the FIFO head as it arrives, with variable latency. It flags the first divergence, an underflow, an overflow or a stall timeout, then freezes so the failing instruction stays observable.

## Interface
- XLEN, 32 (riscv_pkg::XLEN), data/address width
- DEPTH, 8, FIFO entries; power of two, ≥2
- TIMEOUT, 64, max cycles FIFO may stay non-empty with no DUT retire
- clk_i  in  1  clock; all logic on posedge
- rst_i  in  1  reset; synchronous, active-high
- model_valid_i  in  1  model retired one instruction this cycle
- model_pc_i / model_instr_i  in  XLEN each  model retire pc / instruction
- model_rd_addr_i  in  5  model destination register (0 = no write)
- model_rd_data_i  in  XLEN  model write-back value
- model_ready_o  out  1  FIFO not full; model clock-enable is gated with it
- dut_valid_i  in  1  core retired one instruction this cycle
- dut_pc_i / dut_instr_i  in  XLEN each  core retire pc / instruction
- dut_rd_addr_i  in  5  core destination register
- dut_rd_data_i  in  XLEN  core write-back value
- fail_o  out  1  sticky failure flag
- err_o  out  3  checker_err_e code of first failure
- err_fields_o  out  4  {pc, instr, rd_addr, rd_data} mismatch bits
- err_pc_o  out  XLEN  expected pc at failure (FIFO head)
- retired_cnt_o  out  32  count of matched retires
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- States: RUN, FAIL. Reset → RUN, FIFO empty, all outputs 0 except model_ready_o=1.
- Push: model_valid_i in RUN writes the record at the tail.
- Pop/compare: dut_valid_i in RUN with FIFO non-empty pops the head and compares all four fields.
- rd_data is compared only when the expected rd_addr ≠ 0. An rd_addr field mismatch is still flagged.
- All fields equal → retired_cnt_o +1 (wraps at 2^32). Any field differs → FAIL, err=ERR_MISMATCH, err_fields_o set per field.
- Underflow: dut_valid_i with FIFO empty → FAIL, ERR_UNDERFLOW. A model push in the same cycle does not rescue it; there is no bypass.
- Overflow: model_valid_i while full with no same-cycle pop → FAIL, ERR_OVERFLOW, record dropped. Push+pop when full is legal and the level is unchanged.
- Push+pop when level ≥1 is legal.
- Timeout: an idle counter clears on any pop or while the FIFO is empty, otherwise increments. When it reaches TIMEOUT → FAIL, ERR_TIMEOUT.
- Priority when several errors coincide: MISMATCH > UNDERFLOW > OVERFLOW > TIMEOUT.
- FAIL: inputs are ignored, FIFO and counters freeze, and model_ready_o=0. All err/fail outputs hold until rst_i.
- Reset mid-operation flushes the FIFO and clears every error and counter on the next edge.

## Timing
- Push visible in level_o one cycle after model_valid_i.
- Compare result registered: fail_o/err_o/err_fields_o/err_pc_o assert on the edge after the offending dut_valid_i. retired_cnt_o updates at the same edge.
- model_ready_o is combinational from the level/state; it is never 1 in FAIL.
- Timeout fires at the edge on which the idle count reaches TIMEOUT, i.e. TIMEOUT cycles after the last pop or first push.
- Minimum model-to-compare latency: 1 cycle (push at edge N, pop legal in cycle N+1).

## Structure
- riscv_pkg gains:
  - retire_rec_t packed struct {pc, instr, rd_addr, rd_data}
  - checker_err_e enum {ERR_NONE=0, ERR_MISMATCH, ERR_UNDERFLOW, ERR_OVERFLOW, ERR_TIMEOUT}
  - the field-bit index constants
- Sub-module retire_fifo is parameterized on DEPTH:
  - synchronous FIFO of retire_rec_t
  - push/pop/full/empty/level
  - extra-MSB pointers for full/empty disambiguation
- The checker top holds the FSM, comparator, idle counter and error capture.

## Test plan
- 5 records pushed (pc 0x8000_0000..0x8000_0010, addi x1..x5), DUT replays them 3 cycles later → retired_cnt_o=5, fail_o=0, level_o=0.
- DUT rd_data 0x11 vs expected 0x10 on the 3rd record → fail_o next edge, err_o=ERR_MISMATCH, err_fields_o=0001, err_pc_o=0x8000_0008. Later matching traffic leaves retired_cnt_o=2.
- Store record (rd_addr=0) with differing rd_data → no failure. Same record with DUT rd_addr=1 → err_fields_o=0010.
- dut_valid_i on empty FIFO, including with a simultaneous model push → ERR_UNDERFLOW.
- Fill 8 entries:
  - push+pop in the same cycle → no error, level stays 8
  - push alone → ERR_OVERFLOW, model_ready_o=0
- One record pushed, no DUT retire for 64 cycles → ERR_TIMEOUT at cycle 64. Assert rst_i → all outputs 0 and model_ready_o=1 next edge.
